// File: rtl/lc3_param_regfile_if.sv
// Register-file bus: write port, condition-code load and two read ports.
// The master drives addresses/data; the slave (register file) returns read data and NZP.
interface lc3_param_regfile_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
);
   logic              WE;
   logic [ADDR_W-1:0] DR;
   logic [WIDTH-1:0]  D;
   logic              LD_CC;
   logic [ADDR_W-1:0] SR1;
   logic [ADDR_W-1:0] SR2;
   logic [WIDTH-1:0]  Q1;
   logic [WIDTH-1:0]  Q2;
   logic [2:0]        NZP;

   modport master (
      output WE, DR, D, LD_CC, SR1, SR2,
      input  Q1, Q2, NZP
   );

   modport slave (
      input  WE, DR, D, LD_CC, SR1, SR2,
      output Q1, Q2, NZP
   );
endinterface

// File: rtl/lc3_param_regfile.sv
// LC-3 register file: DEPTH x WIDTH registers, one synchronous write port, two
// combinational read ports with optional write forwarding, plus the NZP register.
module lc3_param_regfile #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter bit BYPASS = 1'b1
) (
   input logic               Clk,
   input logic               Reset,
   lc3_param_regfile_if.slave rf
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [2:0]       r_nzp;
   logic [2:0]       w_nzp_next;
   logic [WIDTH-1:0] w_q1;
   logic [WIDTH-1:0] w_q2;
   logic             w_fwd1;
   logic             w_fwd2;

   // NOTE: every output of this block is given a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_nzp_next = 3'b001;
      if (rf.D[WIDTH-1]) begin
         w_nzp_next = 3'b100;
      end else if (rf.D == '0) begin
         w_nzp_next = 3'b010;
      end
   end

   // NOTE: the whole array is cleared on reset, which keeps it in flops rather than a RAM macro;
   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_nzp <= 3'b010;
      end else begin
         if (rf.WE) begin
            r_regs[rf.DR] <= rf.D;
         end
         if (rf.LD_CC) begin
            r_nzp <= w_nzp_next;
         end
      end
   end

   // Forwarding is gated by Reset so a write that reset will discard is never seen.
   assign w_fwd1 = BYPASS && rf.WE && !Reset && (rf.DR == rf.SR1);
   assign w_fwd2 = BYPASS && rf.WE && !Reset && (rf.DR == rf.SR2);

   always_comb begin
      w_q1 = r_regs[rf.SR1];
      w_q2 = r_regs[rf.SR2];
      if (w_fwd1) begin
         w_q1 = rf.D;
      end
      if (w_fwd2) begin
         w_q2 = rf.D;
      end
   end

   assign rf.Q1  = w_q1;
   assign rf.Q2  = w_q2;
   assign rf.NZP = r_nzp;

endmodule

// File: tb/tb_lc3_param_regfile.sv
// Bench for lc3_param_regfile: three instances (16x8 bypass, 16x8 no bypass, 32x16 bypass)
// checked every cycle against an array model, plus hand-computed directed expectations.
module tb_lc3_param_regfile;

   logic Clk;
   logic Reset;

   lc3_param_regfile_if #(.WIDTH(16), .ADDR_W(3)) rf_a ();
   lc3_param_regfile_if #(.WIDTH(16), .ADDR_W(3)) rf_b ();
   lc3_param_regfile_if #(.WIDTH(32), .ADDR_W(4)) rf_c ();

   lc3_param_regfile #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b1)) dut_a (
      .Clk(Clk), .Reset(Reset), .rf(rf_a.slave)
   );
   lc3_param_regfile #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b0)) dut_b (
      .Clk(Clk), .Reset(Reset), .rf(rf_b.slave)
   );
   lc3_param_regfile #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .BYPASS(1'b1)) dut_c (
      .Clk(Clk), .Reset(Reset), .rf(rf_c.slave)
   );

   // The no-bypass instance sees exactly the same stimulus as the bypass one.
   assign rf_b.WE    = rf_a.WE;
   assign rf_b.DR    = rf_a.DR;
   assign rf_b.D     = rf_a.D;
   assign rf_b.LD_CC = rf_a.LD_CC;
   assign rf_b.SR1   = rf_a.SR1;
   assign rf_b.SR2   = rf_a.SR2;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] m16 [8];
   logic [2:0]  m16_nzp;
   logic [31:0] m32 [16];
   logic [2:0]  m32_nzp;
   bit          seen_reset = 1'b0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] nzp_of(input logic [31:0] v, input int w);
      if (v[w-1])  return 3'b100;
      if (v == 0)  return 3'b010;
      return 3'b001;
   endfunction

   // Model: registers are plain arrays updated on each rising edge from the sampled inputs.
   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++)  m16[i] = '0;
         for (int i = 0; i < 16; i++) m32[i] = '0;
         m16_nzp    = 3'b010;
         m32_nzp    = 3'b010;
         seen_reset = 1'b1;
      end else begin
         if (rf_a.WE)    m16[rf_a.DR] = rf_a.D;
         if (rf_a.LD_CC) m16_nzp = nzp_of({16'h0, rf_a.D}, 16);
         if (rf_c.WE)    m32[rf_c.DR] = rf_c.D;
         if (rf_c.LD_CC) m32_nzp = nzp_of(rf_c.D, 32);
      end
   end

   // Every falling edge after the first reset: compare all outputs to the model.
   always @(negedge Clk) begin
      if (seen_reset) begin
         check("a_q1", {16'h0, rf_a.Q1},
               {16'h0, (rf_a.WE && !Reset && rf_a.DR == rf_a.SR1) ? rf_a.D : m16[rf_a.SR1]});
         check("a_q2", {16'h0, rf_a.Q2},
               {16'h0, (rf_a.WE && !Reset && rf_a.DR == rf_a.SR2) ? rf_a.D : m16[rf_a.SR2]});
         check("a_nzp", {29'h0, rf_a.NZP}, {29'h0, m16_nzp});
         check("a_nzp_onehot", $countones(rf_a.NZP), 1);
         check("b_q1", {16'h0, rf_b.Q1}, {16'h0, m16[rf_b.SR1]});
         check("b_q2", {16'h0, rf_b.Q2}, {16'h0, m16[rf_b.SR2]});
         check("b_nzp", {29'h0, rf_b.NZP}, {29'h0, m16_nzp});
         check("c_q1", rf_c.Q1,
               (rf_c.WE && !Reset && rf_c.DR == rf_c.SR1) ? rf_c.D : m32[rf_c.SR1]);
         check("c_q2", rf_c.Q2,
               (rf_c.WE && !Reset && rf_c.DR == rf_c.SR2) ? rf_c.D : m32[rf_c.SR2]);
         check("c_nzp", {29'h0, rf_c.NZP}, {29'h0, m32_nzp});
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // Reset together with a write and CC load at the same edge.
      Reset      = 1'b1;
      rf_a.WE    = 1'b1;
      rf_a.DR    = 3'd3;
      rf_a.D     = 16'hBEEF;
      rf_a.LD_CC = 1'b1;
      rf_a.SR1   = 3'd3;
      rf_a.SR2   = 3'd0;
      rf_c.WE    = 1'b0;
      rf_c.DR    = 4'd0;
      rf_c.D     = 32'h0;
      rf_c.LD_CC = 1'b0;
      rf_c.SR1   = 4'd0;
      rf_c.SR2   = 4'd15;
      tick();
      Reset      = 1'b0;
      rf_a.WE    = 1'b0;
      rf_a.LD_CC = 1'b0;
      #1;
      check("t1_r3_zero", {16'h0, rf_a.Q1}, 32'h0);
      check("t1_nzp", {29'h0, rf_a.NZP}, 32'h2);

      // Two writes with CC load: positive then negative.
      rf_a.WE = 1'b1; rf_a.LD_CC = 1'b1; rf_a.DR = 3'd5; rf_a.D = 16'h1234;
      tick();
      rf_a.DR = 3'd2; rf_a.D = 16'h8001;
      #1;
      check("t2_nzp_pos", {29'h0, rf_a.NZP}, 32'h1);
      tick();
      rf_a.WE = 1'b0; rf_a.LD_CC = 1'b0; rf_a.SR1 = 3'd5; rf_a.SR2 = 3'd2;
      #1;
      check("t2_q1", {16'h0, rf_a.Q1}, 32'h1234);
      check("t2_q2", {16'h0, rf_a.Q2}, 32'h8001);
      check("t2_nzp_neg", {29'h0, rf_a.NZP}, 32'h4);

      // Same-cycle forwarding on both ports, and its absence when disabled.
      rf_a.WE = 1'b1; rf_a.DR = 3'd4; rf_a.D = 16'h0001;
      tick();
      rf_a.D = 16'h00FF; rf_a.SR1 = 3'd4; rf_a.SR2 = 3'd4;
      #1;
      check("t3_byp_q1", {16'h0, rf_a.Q1}, 32'h00FF);
      check("t3_byp_q2", {16'h0, rf_a.Q2}, 32'h00FF);
      check("t3_nobyp_q1", {16'h0, rf_b.Q1}, 32'h0001);
      check("t3_nobyp_q2", {16'h0, rf_b.Q2}, 32'h0001);
      tick();
      rf_a.WE = 1'b0;
      #1;
      check("t3_nobyp_after", {16'h0, rf_b.Q1}, 32'h00FF);

      // CC load without write, then write without CC load.
      rf_a.LD_CC = 1'b1; rf_a.D = 16'h0000; rf_a.SR2 = 3'd7;
      tick();
      rf_a.LD_CC = 1'b0;
      #1;
      check("t4_nzp_zero", {29'h0, rf_a.NZP}, 32'h2);
      check("t4_r4_held", {16'h0, rf_a.Q1}, 32'h00FF);
      check("t4_r7_held", {16'h0, rf_a.Q2}, 32'h0000);
      rf_a.WE = 1'b1; rf_a.DR = 3'd7; rf_a.D = 16'hFFFF;
      tick();
      rf_a.WE = 1'b0; rf_a.SR1 = 3'd7;
      #1;
      check("t4_r7", {16'h0, rf_a.Q1}, 32'hFFFF);
      check("t4_nzp_held", {29'h0, rf_a.NZP}, 32'h2);

      // Sweep all registers of the 16x8 instance.
      for (int i = 0; i < 8; i++) begin
         rf_a.WE = 1'b1; rf_a.DR = 3'(i); rf_a.D = 16'(i * 16'h1111);
         tick();
      end
      rf_a.WE = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rf_a.SR1 = 3'(i); rf_a.SR2 = 3'(7 - i);
         #1;
         check("t5_sweep_q1", {16'h0, rf_a.Q1}, 32'(i * 16'h1111));
         check("t5_sweep_q2", {16'h0, rf_a.Q2}, 32'((7 - i) * 16'h1111));
      end

      // Sweep the 32x16 instance; the last write is negative and loads the CC.
      for (int i = 0; i < 16; i++) begin
         rf_c.WE    = 1'b1;
         rf_c.DR    = 4'(i);
         rf_c.D     = (i == 15) ? 32'h8000_0000 : 32'(i * 32'h1111_1111);
         rf_c.LD_CC = (i == 15);
         tick();
      end
      rf_c.WE = 1'b0; rf_c.LD_CC = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rf_c.SR1 = 4'(i); rf_c.SR2 = 4'(15 - i);
         #1;
         check("t5_c_q1", rf_c.Q1, (i == 15) ? 32'h8000_0000 : 32'(i * 32'h1111_1111));
         check("t5_c_q2", rf_c.Q2, (i == 0) ? 32'h8000_0000 : 32'((15 - i) * 32'h1111_1111));
      end
      check("t5_c_nzp", {29'h0, rf_c.NZP}, 32'h4);

      // Reset arriving mid-operation suppresses forwarding and clears state.
      rf_a.WE = 1'b1; rf_a.DR = 3'd6; rf_a.D = 16'h5555;
      tick();
      Reset = 1'b1; rf_a.D = 16'hAAAA; rf_a.SR1 = 3'd6;
      #1;
      check("t6_q1_during", {16'h0, rf_a.Q1}, 32'h5555);
      tick();
      Reset = 1'b0; rf_a.WE = 1'b0;
      #1;
      check("t6_q1_after", {16'h0, rf_a.Q1}, 32'h0);
      check("t6_nzp_after", {29'h0, rf_a.NZP}, 32'h2);
      check("t6_c_nzp_after", {29'h0, rf_c.NZP}, 32'h2);

      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
